// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared definitions for the multdiv issue controller: FSM state encoding,
// operation codes, default timing parameters and the writeback record.
package multdiv_issue_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;

  // Operation select as carried in the latched is_div bit
  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  // Datapath widths
  localparam int MD_DATA_W = 32;
  localparam int MD_RD_W   = 5;

  // BUSY cycle counter width; 7 bits covers any timeout up to 127
  localparam int MD_CNT_W = 7;

  // Default timing: hang timeout and the ready-mask window after START
  localparam int MD_TIMEOUT_DEFAULT  = 64;
  localparam int MD_RDY_MASK_DEFAULT = 1;

  // Everything handed to writeback for one completed op
  typedef struct packed {
    logic [MD_DATA_W-1:0] data;
    logic                 exception;
    logic                 timeout;
    logic [MD_RD_W-1:0]   rd;
  } md_wb_t;

  // A result flagged as an exception is never exposed; writeback sees zero
  function automatic logic [MD_DATA_W-1:0] md_mask_data(input logic [MD_DATA_W-1:0] data,
                                                        input logic                 exc);
    return exc ? '0 : data;
  endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bus bundles around the multdiv issue controller. The controller is the
// slave of the issue bundle and the master of the unit and writeback bundles.

// Execute stage -> controller
interface multdiv_issue_if;
  import multdiv_issue_ctrl_pkg::*;
  logic                 issue_valid;
  logic                 issue_is_div;
  logic [MD_DATA_W-1:0] issue_opA;
  logic [MD_DATA_W-1:0] issue_opB;
  logic [MD_RD_W-1:0]   issue_rd;
  logic                 issue_ready;
  logic                 stall;

  modport master (
    output issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd,
    input  issue_ready, stall
  );
  modport slave (
    input  issue_valid, issue_is_div, issue_opA, issue_opB, issue_rd,
    output issue_ready, stall
  );
endinterface

// Controller -> multi-cycle multdiv unit
interface multdiv_unit_if;
  import multdiv_issue_ctrl_pkg::*;
  logic [MD_DATA_W-1:0] md_operandA;
  logic [MD_DATA_W-1:0] md_operandB;
  logic                 md_ctrl_MULT;
  logic                 md_ctrl_DIV;
  logic [MD_DATA_W-1:0] md_result;
  logic                 md_exception;
  logic                 md_resultRDY;

  modport master (
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  md_result, md_exception, md_resultRDY
  );
  modport slave (
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output md_result, md_exception, md_resultRDY
  );
endinterface

// Controller -> writeback stage
interface multdiv_wb_if;
  import multdiv_issue_ctrl_pkg::*;
  logic                 wb_valid;
  logic                 wb_ready;
  logic [MD_RD_W-1:0]   wb_rd;
  logic [MD_DATA_W-1:0] wb_data;
  logic                 wb_exception;
  logic                 wb_timeout;

  modport master (
    output wb_valid, wb_rd, wb_data, wb_exception, wb_timeout,
    input  wb_ready
  );
  modport slave (
    input  wb_valid, wb_rd, wb_data, wb_exception, wb_timeout,
    output wb_ready
  );
endinterface

// File: rtl/multdiv_issue_ctrl_md_cycle_counter.sv
// Saturating cycle counter with synchronous clear and count enable, plus a
// terminal-count flag used for the BUSY hang timeout.
module md_cycle_counter
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int WIDTH    = MD_CNT_W,
  parameter int TERMINAL = MD_TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TERM_C = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] MAX_C  = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != MAX_C)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q >= TERM_C);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue sequencer for the multi-cycle multdiv unit: accepts one op, holds the
// operands, pulses the unit's start control once, waits for ready (or times
// out) and hands the result to writeback with a valid/ready handshake.
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT  = MD_TIMEOUT_DEFAULT,  // keep within 40..127
  parameter int RDY_MASK = MD_RDY_MASK_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           flush,
  multdiv_issue_if.slave issue,
  multdiv_unit_if.master md,
  multdiv_wb_if.master   wb
);

  localparam logic [MD_CNT_W-1:0] RDY_MASK_C = MD_CNT_W'(RDY_MASK);

  md_state_e state_q;
  md_state_e state_d;

  logic                 issue_ready_c;
  logic                 accept;
  logic                 complete;
  logic                 rdy_ok;
  logic                 cnt_clear;
  logic                 cnt_en;
  logic [MD_CNT_W-1:0]  cnt;
  logic                 cnt_tc;

  logic [MD_DATA_W-1:0] opa_q;
  logic [MD_DATA_W-1:0] opb_q;
  logic                 is_div_q;
  logic [MD_RD_W-1:0]   rd_q;

  md_wb_t               wb_q;
  md_wb_t               wb_d;

  // Ready is masked by flush so a flushed cycle can never accept an op, and
  // by reset so every output reads zero while reset is held.
  assign issue_ready_c = ((state_q == ST_IDLE) || ((state_q == ST_DONE) && wb.wb_ready))
                         && !flush && !reset;
  assign accept        = issue.issue_valid && issue_ready_c;

  // The unit's ready is only trusted once the mask window after START is over
  assign rdy_ok    = md.md_resultRDY && (cnt > RDY_MASK_C);
  assign cnt_clear = accept;
  assign cnt_en    = (state_q == ST_BUSY);

  md_cycle_counter #(
    .WIDTH    (MD_CNT_W),
    .TERMINAL (TIMEOUT)
  ) u_cycle_counter (
    .clock   (clock),
    .reset   (reset),
    .clear_i (cnt_clear),
    .en_i    (cnt_en),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  // Next-state logic; flush overrides every other event
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) state_d = ST_START;
        end
        ST_START: begin
          state_d = ST_BUSY;
        end
        ST_BUSY: begin
          if (rdy_ok || cnt_tc) begin
            state_d  = ST_DONE;
            complete = 1'b1;
          end
        end
        ST_DONE: begin
          if (accept) begin
            state_d = ST_START;
          end else if (wb.wb_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand and op-info registers, loaded only when an op is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      opa_q    <= '0;
      opb_q    <= '0;
      is_div_q <= MD_OP_MULT;
      rd_q     <= '0;
    end else if (accept) begin
      opa_q    <= issue.issue_opA;
      opb_q    <= issue.issue_opB;
      is_div_q <= issue.issue_is_div;
      rd_q     <= issue.issue_rd;
    end
  end

  // Completion record: a real result beats a timeout landing on the same cycle
  always_comb begin
    wb_d.rd = rd_q;
    if (rdy_ok) begin
      wb_d.data      = md_mask_data(md.md_result, md.md_exception);
      wb_d.exception = md.md_exception;
      wb_d.timeout   = 1'b0;
    end else begin
      wb_d.data      = '0;
      wb_d.exception = 1'b1;
      wb_d.timeout   = 1'b1;
    end
  end

  // Writeback register, loaded only on BUSY->DONE so it holds while stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q <= '0;
    end else if (complete) begin
      wb_q <= wb_d;
    end
  end

  assign issue.issue_ready = issue_ready_c;
  assign issue.stall       = issue.issue_valid && !issue_ready_c && !reset;

  assign md.md_operandA  = opa_q;
  assign md.md_operandB  = opb_q;
  assign md.md_ctrl_MULT = (state_q == ST_START) && (is_div_q == MD_OP_MULT);
  assign md.md_ctrl_DIV  = (state_q == ST_START) && (is_div_q == MD_OP_DIV);

  assign wb.wb_valid     = (state_q == ST_DONE);
  assign wb.wb_rd        = wb_q.rd;
  assign wb.wb_data      = wb_q.data;
  assign wb.wb_exception = wb_q.exception;
  assign wb.wb_timeout   = wb_q.timeout;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl. The bench plays the multdiv
// unit itself, computing results arithmetically and deciding per op on which
// BUSY cycle it raises ready.
module tb_multdiv_issue_ctrl;
  import multdiv_issue_ctrl_pkg::*;

  localparam int TIMEOUT  = 64;
  localparam int RDY_MASK = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  multdiv_issue_if issue_bus ();
  multdiv_unit_if  md_bus ();
  multdiv_wb_if    wb_bus ();

  multdiv_issue_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .RDY_MASK (RDY_MASK)
  ) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .issue (issue_bus.slave),
    .md    (md_bus.master),
    .wb    (wb_bus.master)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Op currently being issued
  logic        op_div;
  logic [31:0] op_a, op_b, op_raw, op_data;
  logic        op_exc;
  logic [4:0]  op_rd;
  // Expected writeback once the op completes
  logic [31:0] wbx_data;
  logic        wbx_exc, wbx_to;
  logic [4:0]  wbx_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reference multdiv unit: signed MULT overflows outside the 32-bit signed
  // range, DIV by zero or INT_MIN/-1 is an exception.
  task automatic unit_model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] raw, output logic exc);
    longint p;
    int     sa, sb;
    exc = 1'b0;
    raw = $urandom;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      if (p > 64'sd2147483647 || p < -64'sd2147483648) exc = 1'b1;
      else raw = p[31:0];
    end else begin
      sa = a;
      sb = b;
      if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) exc = 1'b1;
      else raw = sa / sb;
    end
  endtask

  // Present an op on the issue bus and work out what the unit will return
  task automatic prepare_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd);
    op_div = is_div;
    op_a   = a;
    op_b   = b;
    op_rd  = rd;
    unit_model(is_div, a, b, op_raw, op_exc);
    op_data = op_exc ? 32'd0 : op_raw;
    issue_bus.issue_valid  = 1'b1;
    issue_bus.issue_is_div = is_div;
    issue_bus.issue_opA    = a;
    issue_bus.issue_opB    = b;
    issue_bus.issue_rd     = rd;
  endtask

  // Issue from IDLE: ready must be up, op accepted on the next edge
  task automatic issue_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    prepare_op(is_div, a, b, rd);
    settle();
    check("idle_ready", issue_bus.issue_ready, 1);
    check("idle_stall", issue_bus.stall, 0);
    tick();
    issue_bus.issue_valid = 1'b0;
  endtask

  // Entered in START. Raises ready on BUSY cycle rdy_at (0 = never); with
  // spurious set, ready is also pulsed with junk in START and the mask window.
  task automatic run_to_done(input int rdy_at, input bit spurious);
    bit done;
    bit real_ok;
    bit rdy_now;
    int k;
    md_bus.md_resultRDY = spurious;
    md_bus.md_result    = 32'hDEAD_BEEF;
    md_bus.md_exception = 1'b0;
    settle();
    check("start_mult", md_bus.md_ctrl_MULT, !op_div);
    check("start_div", md_bus.md_ctrl_DIV, op_div);
    check("start_opA", md_bus.md_operandA, op_a);
    check("start_opB", md_bus.md_operandB, op_b);
    check("start_wbv", wb_bus.wb_valid, 0);
    tick();
    done = 1'b0;
    k    = 0;
    while (!done && k <= TIMEOUT + 2) begin
      k++;
      rdy_now = (k == rdy_at) || (spurious && k <= RDY_MASK + 1);
      md_bus.md_resultRDY = rdy_now;
      md_bus.md_result    = (k == rdy_at) ? op_raw : 32'hDEAD_BEEF;
      md_bus.md_exception = (k == rdy_at) ? op_exc : 1'b1;
      settle();
      check("busy_ctrl", {md_bus.md_ctrl_MULT, md_bus.md_ctrl_DIV}, 0);
      check("busy_opA", md_bus.md_operandA, op_a);
      check("busy_opB", md_bus.md_operandB, op_b);
      check("busy_wbv", wb_bus.wb_valid, 0);
      // k-1 earlier BUSY cycles have been counted when this one is evaluated
      real_ok = (k == rdy_at) && ((k - 1) > RDY_MASK);
      done    = real_ok || ((k - 1) >= TIMEOUT);
      if (done) begin
        wbx_to   = !real_ok;
        wbx_exc  = real_ok ? op_exc : 1'b1;
        wbx_data = real_ok ? op_data : 32'd0;
        wbx_rd   = op_rd;
      end
      tick();
    end
    md_bus.md_resultRDY = 1'b0;
    settle();
    check("done_reached", done, 1);
    check_wb("done");
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_wbv"}, wb_bus.wb_valid, 1);
    check({tag, "_data"}, wb_bus.wb_data, wbx_data);
    check({tag, "_exc"}, wb_bus.wb_exception, wbx_exc);
    check({tag, "_to"}, wb_bus.wb_timeout, wbx_to);
    check({tag, "_rd"}, wb_bus.wb_rd, wbx_rd);
  endtask

  // Hold wb_ready low for some cycles, then retire the result to IDLE
  task automatic drain(input int hold);
    wb_bus.wb_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      settle();
      check_wb("hold");
      check("hold_ready", issue_bus.issue_ready, 0);
      tick();
    end
    wb_bus.wb_ready = 1'b1;
    settle();
    check("drain_ready", issue_bus.issue_ready, 1);
    tick();
    settle();
    check("drain_wbv", wb_bus.wb_valid, 0);
    check("drain_ctrl", {md_bus.md_ctrl_MULT, md_bus.md_ctrl_DIV}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, issue_bus.issue_ready, 0);
    check({tag, "_stall"}, issue_bus.stall, 0);
    check({tag, "_ctrl"}, {md_bus.md_ctrl_MULT, md_bus.md_ctrl_DIV}, 0);
    check({tag, "_opA"}, md_bus.md_operandA, 0);
    check({tag, "_opB"}, md_bus.md_operandB, 0);
    check({tag, "_wbv"}, wb_bus.wb_valid, 0);
    check({tag, "_data"}, wb_bus.wb_data, 0);
    check({tag, "_exc"}, {wb_bus.wb_exception, wb_bus.wb_timeout}, 0);
    check({tag, "_rd"}, wb_bus.wb_rd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    issue_bus.issue_valid  = 1'b0;
    issue_bus.issue_is_div = 1'b0;
    issue_bus.issue_opA    = '0;
    issue_bus.issue_opB    = '0;
    issue_bus.issue_rd     = '0;
    md_bus.md_result       = '0;
    md_bus.md_exception    = 1'b0;
    md_bus.md_resultRDY    = 1'b0;
    wb_bus.wb_ready        = 1'b1;

    // Power-on reset
    tick();
    tick();
    settle();
    check_all_zero("reset");
    reset = 1'b0;
    settle();
    check("post_reset_ready", issue_bus.issue_ready, 1);

    // MULT 7 * -3
    issue_op(MD_OP_MULT, 32'd7, -32'sd3, 5'd5);
    run_to_done(4, 0);
    check("mult_neg", wb_bus.wb_data, 32'hFFFF_FFEB);
    drain(0);

    // DIV 100 / 7 with junk ready in START and the mask window
    issue_op(MD_OP_DIV, 32'd100, 32'd7, 5'd9);
    run_to_done(4, 1);
    check("div_100_7", wb_bus.wb_data, 32'd14);
    drain(0);

    // DIV 5 / 0
    issue_op(MD_OP_DIV, 32'd5, 32'd0, 5'd2);
    run_to_done(3, 0);
    check("div0_exc", {wb_bus.wb_exception, wb_bus.wb_timeout}, 2'b10);
    drain(0);

    // MULT overflow
    issue_op(MD_OP_MULT, 32'h0001_0000, 32'h0001_0000, 5'd31);
    run_to_done(5, 0);
    check("mult_ovf", {wb_bus.wb_exception, wb_bus.wb_data}, {1'b1, 32'd0});
    drain(0);

    // Writeback stalled 5 cycles with a pending issue, then back-to-back
    issue_op(MD_OP_MULT, 32'd123, 32'd456, 5'd11);
    run_to_done(3, 0);
    wb_bus.wb_ready = 1'b0;
    prepare_op(MD_OP_DIV, 32'd1000, -32'sd10, 5'd17);
    for (int i = 0; i < 5; i++) begin
      settle();
      check("b2b_stall", issue_bus.stall, 1);
      check("b2b_ready", issue_bus.issue_ready, 0);
      check_wb("b2b_hold");
      tick();
    end
    wb_bus.wb_ready = 1'b1;
    settle();
    check("b2b_accept", issue_bus.issue_ready, 1);
    check("b2b_nostall", issue_bus.stall, 0);
    tick();
    issue_bus.issue_valid = 1'b0;
    run_to_done(4, 0);
    check("b2b_div", wb_bus.wb_data, 32'hFFFF_FF9C);
    drain(2);

    // Flush on BUSY cycle 10
    issue_op(MD_OP_DIV, 32'd50, 32'd5, 5'd3);
    tick();
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    settle();
    check("flush_wbv_pre", wb_bus.wb_valid, 0);
    tick();
    flush = 1'b0;
    settle();
    check("flush_idle_ready", issue_bus.issue_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_wb", wb_bus.wb_valid, 0);
      check("flush_no_ctrl", {md_bus.md_ctrl_MULT, md_bus.md_ctrl_DIV}, 0);
      tick();
    end

    // Flush with a simultaneous issue in IDLE drops the issue
    prepare_op(MD_OP_MULT, 32'd2, 32'd2, 5'd1);
    flush = 1'b1;
    settle();
    check("flush_mask_ready", issue_bus.issue_ready, 0);
    check("flush_stall", issue_bus.stall, 1);
    tick();
    flush = 1'b0;
    issue_bus.issue_valid = 1'b0;
    settle();
    check("flush_drop", {md_bus.md_ctrl_MULT, md_bus.md_ctrl_DIV}, 0);
    check("flush_drop_ready", issue_bus.issue_ready, 1);

    // DIV 9 / 3 after the flush
    issue_op(MD_OP_DIV, 32'd9, 32'd3, 5'd7);
    run_to_done(3, 0);
    check("div_9_3", wb_bus.wb_data, 32'd3);
    drain(0);

    // Hang: ready never comes
    issue_op(MD_OP_MULT, 32'd3, 32'd4, 5'd6);
    run_to_done(0, 0);
    check("timeout_flags", {wb_bus.wb_timeout, wb_bus.wb_exception}, 2'b11);
    drain(0);

    // Ready on the very cycle the timeout fires: real result wins
    issue_op(MD_OP_MULT, 32'd3, 32'd4, 5'd8);
    run_to_done(TIMEOUT + 1, 0);
    check("rdy_vs_timeout", {wb_bus.wb_timeout, wb_bus.wb_data}, {1'b0, 32'd12});
    drain(0);

    // Reset in the middle of BUSY
    issue_op(MD_OP_DIV, 32'd77, 32'd7, 5'd4);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    settle();
    check_all_zero("mid_reset");
    reset = 1'b0;
    settle();
    check("mid_reset_ready", issue_bus.issue_ready, 1);

    // Randomised ops
    for (int n = 0; n < 16; n++) begin
      logic        rdiv;
      logic [31:0] ra, rb;
      int          sel;
      rdiv = 1'($urandom_range(0, 1));
      ra   = $urandom;
      sel  = $urandom_range(0, 3);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) rb = $urandom;
      else rb = 32'($urandom_range(1, 300)) ^ ({32{sel == 3}});
      issue_op(rdiv, ra, rb, 5'($urandom_range(0, 31)));
      run_to_done($urandom_range(1, 8), 1'($urandom_range(0, 1)));
      drain($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
